ccff_chain_loader: RTL
======================

// Module: ccff_chain_loader
// PURPOSE
//  Drives the configuration-chain protocol into a tile: serializes bitstream words onto ccff_head with a per-bit shift enable.
//  One loader per chain, sitting at the head of an sb/cb/grid ccff chain.
//  ccff_head of the chain connects to this block's ccff_head; the chain's ccff_tail returns on ccff_tail.
//  Shifting stops after exactly CHAIN_LEN bits. The loaded chain then holds the mux sram/sram_inv configuration.
// PARAMETERS
//  CHAIN_LEN  30  number of config bits in the chain (sb_1__0_ = 30); must be >= 1
//  WORD_W     8   width of an input bitstream word
//  CNT_W      16  width of bit_count; 2**CNT_W must exceed CHAIN_LEN
// PORTS
//  prog_clk      in   1         configuration clock
//  prog_reset_n  in   1         asynchronous active-low reset
//  start         in   1         one-cycle pulse that begins a load
//  word_data     in   WORD_W    bitstream word; bit WORD_W-1 is shifted first
//  word_valid    in   1         word_data valid
//  word_ready    out  1         loader accepts word_data this cycle
//  ccff_head     out  1         serial config bit to chain head
//  ccff_shift_en out  1         chain shifts on the prog_clk edge where this is 1
//  ccff_tail     in   1         serial bit returning from chain tail
//  busy          out  1         load in progress
//  done          out  1         load complete; held until next accepted start
//  bit_count     out  CNT_W     bits shifted in current/last load
//  rb_data       out  WORD_W    readback word (see CONFIGURATION)
//  rb_valid      out  1         rb_data valid, one-cycle pulse
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, bit_count=0. Asynchronous assertion aborts any load at once, with ccff_shift_en forced to 0.
//  - Registered outputs: ccff_head, ccff_shift_en, done, bit_count, rb_* are all registered. word_ready and busy decode from FSM state.
//  - FSM states: IDLE, FETCH, SHIFT, DONE.
//  - IDLE / DONE: start=1 -> FETCH. On that edge bit_count<=0 and done<=0.
//  - Start while busy: a start in FETCH or SHIFT is ignored.
//  - FETCH: word_ready=1, ccff_shift_en=0 (chain holds).
//    - On word_valid&word_ready: sreg<=word_data, bits_left<=WORD_W, go to SHIFT.
//    - While word_valid=0: stay in FETCH indefinitely.
//  - SHIFT: each cycle ccff_head<=sreg[WORD_W-1], ccff_shift_en<=1, sreg<<=1, bits_left--, bit_count++.
//    - Bit CHAIN_LEN shifted -> DONE. Any unshifted low bits of the current word are discarded.
//    - Else if bits_left reaches 0 -> FETCH.
//  - DONE: done<=1, busy=0, ccff_shift_en<=0.
//  - busy=1 in FETCH and SHIFT.
//  - Latency: from word accept, the first ccff_head/ccff_shift_en pair is valid 1 cycle later.
//    Each word costs WORD_W shift cycles plus 1 fetch cycle (no prefetch).
//  - Bit order: the first bit shifted lands in the tail-most chain flop. Host supplies the bitstream tail-first.
//  - Exact multiple: if CHAIN_LEN % WORD_W == 0, no extra word is fetched after the last one.
//  - Count width: bit_count never exceeds CHAIN_LEN and has no wrap-around.
// CONFIGURATION
//  CCFF_READBACK_EN defined:
//   - Timing: ccff_tail is sampled on every edge where ccff_shift_en=1, giving the old chain contents, oldest-tail bit first.
//   - Packing: bits pack MSB-first into rb_data. rb_valid pulses one cycle after each WORD_W bits.
//   - Final partial word: pulsed on the DONE entry cycle, zero-padded in the low bits.
//   - No backpressure.
//  CCFF_READBACK_EN undefined:
//   - rb_data=0 and rb_valid=0 permanently. The ports remain present.
//   - ccff_tail is unused.
// TESTING
//  - Basic load, CHAIN_LEN=30, WORD_W=8, words A5,3C,FF,81 with word_valid=1:
//    ccff_head = 10100101 00111100 11111111 100000.
//    shift_en high 30 cycles in 4 bursts (8,8,8,6). 4 words accepted. done=1, bit_count=30.
//  - Backpressure: word_valid low 5 cycles before word 2 -> FETCH held 5 extra cycles with shift_en=0.
//    bit_count frozen at 8. The output stream is otherwise identical.
//  - Exact multiple: CHAIN_LEN=16, words 12,34 -> exactly 2 accepts, word_ready never rises again, done after bit 16.
//  - Reset mid-shift: prog_reset_n low at bit_count=13 -> same-cycle shift_en=0, all outputs 0.
//    A new start then reloads from bit 0.
//  - Start while busy: start pulsed at bit_count=5 -> ignored. Load completes normally at 30.
//  - Readback (macro on): chain model preloaded with 30'h2AAAAAAA, reload any pattern.
//    rb_data = 55,55,55,54 (last padded). rb_valid pulses 4 times.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serializes bitstream words MSB-first onto ccff_head for exactly CHAIN_LEN bits.
// Define CCFF_READBACK_EN to capture the old chain contents from ccff_tail into rb_data/rb_valid.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 30,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);
    localparam int BL_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [BL_W-1:0]  WORD_BITS = BL_W'(WORD_W);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [BL_W-1:0]   bits_left_q, bits_left_d;
    logic [CNT_W-1:0]  bit_count_q, bit_count_d;
    logic              head_q, head_d;
    logic              shift_en_q, shift_en_d;
    logic              done_q, done_d;

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            bits_left_q <= '0;
            bit_count_q <= '0;
            head_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            bits_left_q <= bits_left_d;
            bit_count_q <= bit_count_d;
            head_q      <= head_d;
            shift_en_q  <= shift_en_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bits_left_d = bits_left_q;
        bit_count_d = bit_count_q;
        head_d      = head_q;
        shift_en_d  = 1'b0;
        done_d      = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = FETCH;
                    bit_count_d = '0;
                    done_d      = 1'b0;
                end else if (state_q == DONE) begin
                    done_d = 1'b1;
                end
            end
            FETCH: begin
                if (word_valid) begin
                    sreg_d      = word_data;
                    bits_left_d = WORD_BITS;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                head_d      = sreg_q[WORD_W-1];
                shift_en_d  = 1'b1;
                sreg_d      = sreg_q << 1;
                bits_left_d = bits_left_q - BL_W'(1);
                bit_count_d = bit_count_q + CNT_W'(1);
                // Chain length wins over word boundary: leftover low bits are dropped.
                if (bit_count_q == LAST_BIT) begin
                    state_d = DONE;
                end else if (bits_left_q == BL_W'(1)) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign word_ready    = (state_q == FETCH);
    assign busy          = (state_q == FETCH) || (state_q == SHIFT);
    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign done          = done_q;
    assign bit_count     = bit_count_q;

`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] rb_acc_q, rb_acc_d, rb_acc_w;
    logic [WORD_W-1:0] rb_data_q, rb_data_d;
    logic [BL_W-1:0]   rb_idx_q, rb_idx_d;
    logic              rb_valid_q, rb_valid_d;

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            rb_acc_q   <= '0;
            rb_data_q  <= '0;
            rb_idx_q   <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_acc_q   <= rb_acc_d;
            rb_data_q  <= rb_data_d;
            rb_idx_q   <= rb_idx_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    // The tail bit leaving the chain on each shifting edge is the old content, oldest first.
    always_comb begin
        rb_acc_w   = (rb_acc_q << 1) | WORD_W'(ccff_tail);
        rb_acc_d   = rb_acc_q;
        rb_idx_d   = rb_idx_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        if (shift_en_q) begin
            if (rb_idx_q == WORD_BITS - BL_W'(1) || state_q == DONE) begin
                rb_data_d  = rb_acc_w << (WORD_BITS - BL_W'(1) - rb_idx_q);
                rb_valid_d = 1'b1;
                rb_acc_d   = '0;
                rb_idx_d   = '0;
            end else begin
                rb_acc_d = rb_acc_w;
                rb_idx_d = rb_idx_q + BL_W'(1);
            end
        end
    end

    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign rb_data     = '0;
    assign rb_valid    = 1'b0;
`endif

endmodule
